// File: rtl/id_issue_stage.sv
// Decode/issue pipeline stage: holds one instruction until both operands wake up and EXE accepts.
// Also counts operand-stall cycles and flags a stall run that reaches STALL_LIMIT.
module id_issue_stage #(
    parameter int BUS_WD      = 64,
    parameter int CNT_WD      = 16,
    parameter int STALL_LIMIT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              IF_to_ID_valid,
    input  logic [BUS_WD-1:0] IF_to_ID_bus,
    output logic              ID_allowin,
    input  logic              src_1_ready,
    input  logic              src_2_ready,
    input  logic              EXE_allowin,
    input  logic              br_flush,
    output logic              ID_to_EXE_valid,
    output logic [BUS_WD-1:0] ID_to_EXE_bus,
    output logic              ID_valid_o,
    output logic [CNT_WD-1:0] stall_cnt,
    output logic              stall_timeout
);

    localparam int RUN_WD = (STALL_LIMIT < 1) ? 1 : $clog2(STALL_LIMIT + 1);
    localparam logic [RUN_WD-1:0] RUN_MAX = RUN_WD'(STALL_LIMIT);

    logic              valid_q, valid_d;
    logic [BUS_WD-1:0] bus_q, bus_d;
    logic [CNT_WD-1:0] cnt_q, cnt_d;
    logic [RUN_WD-1:0] run_q, run_d;
    logic              timeout_q, timeout_d;

    logic ready_go;
    logic op_stall;
    logic accept;

    assign ready_go        = src_1_ready & src_2_ready;
    assign ID_allowin      = !valid_q | (ready_go & EXE_allowin);
    assign ID_to_EXE_valid = valid_q & ready_go & !br_flush;
    assign op_stall        = valid_q & !ready_go & !br_flush;
    assign accept          = IF_to_ID_valid & ID_allowin & !br_flush;

    always_comb begin
        valid_d   = valid_q;
        bus_d     = bus_q;
        cnt_d     = cnt_q;
        run_d     = run_q;
        timeout_d = timeout_q;

        if (br_flush)
            valid_d = 1'b0;
        else if (ID_allowin)
            valid_d = IF_to_ID_valid;

        if (accept)
            bus_d = IF_to_ID_bus;

        // Only operand stalls count; EXE back-pressure and flush cycles end a run.
        if (op_stall) begin
            if (!(&cnt_q))
                cnt_d = cnt_q + CNT_WD'(1);
            if (run_q != RUN_MAX)
                run_d = run_q + RUN_WD'(1);
            if (run_d == RUN_MAX)
                timeout_d = 1'b1;
        end else begin
            run_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            bus_q     <= '0;
            cnt_q     <= '0;
            run_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            bus_q     <= bus_d;
            cnt_q     <= cnt_d;
            run_q     <= run_d;
            timeout_q <= timeout_d;
        end
    end

    assign ID_to_EXE_bus = bus_q;
    assign ID_valid_o    = valid_q;
    assign stall_cnt     = cnt_q;
    assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_id_issue_stage.sv
// Bench for id_issue_stage: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_id_issue_stage;

    localparam int BUS_WD      = 64;
    localparam int CNT_WD      = 4;
    localparam int STALL_LIMIT = 4;
    localparam int CNT_MAX     = (1 << CNT_WD) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              IF_to_ID_valid = 1'b0;
    logic [BUS_WD-1:0] IF_to_ID_bus = '0;
    logic              ID_allowin;
    logic              src_1_ready = 1'b0;
    logic              src_2_ready = 1'b0;
    logic              EXE_allowin = 1'b0;
    logic              br_flush = 1'b0;
    logic              ID_to_EXE_valid;
    logic [BUS_WD-1:0] ID_to_EXE_bus;
    logic              ID_valid_o;
    logic [CNT_WD-1:0] stall_cnt;
    logic              stall_timeout;

    id_issue_stage #(
        .BUS_WD(BUS_WD),
        .CNT_WD(CNT_WD),
        .STALL_LIMIT(STALL_LIMIT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .IF_to_ID_valid(IF_to_ID_valid),
        .IF_to_ID_bus(IF_to_ID_bus),
        .ID_allowin(ID_allowin),
        .src_1_ready(src_1_ready),
        .src_2_ready(src_2_ready),
        .EXE_allowin(EXE_allowin),
        .br_flush(br_flush),
        .ID_to_EXE_valid(ID_to_EXE_valid),
        .ID_to_EXE_bus(ID_to_EXE_bus),
        .ID_valid_o(ID_valid_o),
        .stall_cnt(stall_cnt),
        .stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: slot occupancy, held payload, counters.
    bit              m_valid;
    bit [BUS_WD-1:0] m_bus;
    int              m_cnt;
    int              m_run;
    bit              m_to;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_valid = 0;
        m_bus   = '0;
        m_cnt   = 0;
        m_run   = 0;
        m_to    = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"},   64'(ID_valid_o), 64'd0);
        chk({tag, "_exe_vld"}, 64'(ID_to_EXE_valid), 64'd0);
        chk({tag, "_bus"},     64'(ID_to_EXE_bus), 64'd0);
        chk({tag, "_cnt"},     64'(stall_cnt), 64'd0);
        chk({tag, "_timeout"}, 64'(stall_timeout), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        IF_to_ID_valid = 0; src_1_ready = 0; src_2_ready = 0; EXE_allowin = 0; br_flush = 0;
        #1;
        chk_reset_outputs("rst");
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One clock cycle: drive, compare against the model, then advance the model across the edge.
    task automatic cyc(input bit iv, input logic [BUS_WD-1:0] b, input bit s1, input bit s2,
                       input bit ea, input bit fl);
        bit rg, al, stall;
        @(negedge clk);
        IF_to_ID_valid = iv; IF_to_ID_bus = b; src_1_ready = s1; src_2_ready = s2;
        EXE_allowin = ea; br_flush = fl;
        #1;
        rg    = s1 && s2;
        al    = !m_valid || (rg && ea);
        stall = m_valid && !rg && !fl;
        chk("allowin",   64'(ID_allowin), 64'(al));
        chk("exe_valid", 64'(ID_to_EXE_valid), 64'(m_valid && rg && !fl));
        chk("valid_o",   64'(ID_valid_o), 64'(m_valid));
        chk("bus",       64'(ID_to_EXE_bus), 64'(m_bus));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
        chk("timeout",   64'(stall_timeout), 64'(m_to));
        @(posedge clk);
        if (stall) begin
            m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            m_run = (m_run < STALL_LIMIT) ? m_run + 1 : STALL_LIMIT;
            if (m_run == STALL_LIMIT) m_to = 1;
        end else begin
            m_run = 0;
        end
        if (iv && al && !fl) m_bus = b;
        if (fl) m_valid = 0;
        else if (al) m_valid = iv;
    endtask

    localparam logic [BUS_WD-1:0] OFFER_A = {32'h1c00_0000, 32'h0280_0c0c};
    localparam logic [BUS_WD-1:0] OFFER_B = {32'h1c00_0004, 32'h1500_0004};

    initial begin
        model_reset();
        #1;
        chk_reset_outputs("por");

        // Simple flow
        do_reset();
        cyc(1, OFFER_A, 1, 1, 1, 0);
        #1;
        chk("flow_exe_valid", 64'(ID_to_EXE_valid), 64'd1);
        chk("flow_bus",       64'(ID_to_EXE_bus), 64'(OFFER_A));
        chk("flow_allowin",   64'(ID_allowin), 64'd1);
        cyc(1, OFFER_B, 1, 1, 1, 0);
        cyc(0, '0, 1, 1, 1, 0);

        // Operand stall on src_2
        do_reset();
        cyc(1, OFFER_A, 1, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, OFFER_B, 1, 0, 1, 0);
            chk("stall_bus_stable", 64'(ID_to_EXE_bus), 64'(OFFER_A));
        end
        #1;
        chk("stall_cnt_3", 64'(stall_cnt), 64'd3);
        cyc(0, '0, 1, 1, 1, 0);

        // Flush with simultaneous offer
        do_reset();
        cyc(1, OFFER_A, 1, 1, 1, 0);
        cyc(0, '0, 0, 1, 1, 0);
        cyc(1, OFFER_B, 0, 1, 1, 1);
        #1;
        chk("flush_valid",   64'(ID_valid_o), 64'd0);
        chk("flush_exe_vld", 64'(ID_to_EXE_valid), 64'd0);
        chk("flush_bus",     64'(ID_to_EXE_bus), 64'(OFFER_A));

        // EXE back-pressure is not an operand stall
        do_reset();
        cyc(1, OFFER_A, 1, 1, 1, 0);
        for (int i = 0; i < 5; i++) cyc(1, OFFER_B, 1, 1, 0, 0);
        #1;
        chk("bp_bus",  64'(ID_to_EXE_bus), 64'(OFFER_A));
        chk("bp_cnt",  64'(stall_cnt), 64'd0);

        // Timeout: 3-cycle run, break, 4-cycle run
        do_reset();
        cyc(1, OFFER_A, 1, 1, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0, 1, 0);
        cyc(0, '0, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, '0, 0, 1, 1, 0);
            #1;
            chk("to_flag", 64'(stall_timeout), (i == 3) ? 64'd1 : 64'd0);
        end
        chk("to_cnt_7", 64'(stall_cnt), 64'd7);
        cyc(0, '0, 1, 1, 1, 0);
        cyc(0, '0, 1, 1, 1, 0);
        #1;
        chk("to_sticky", 64'(stall_timeout), 64'd1);

        // Asynchronous reset mid-stall
        do_reset();
        cyc(1, OFFER_A, 1, 1, 1, 0);
        cyc(0, '0, 0, 0, 1, 0);
        cyc(0, '0, 0, 0, 1, 0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outputs("async");
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) do_reset();
            cyc($urandom_range(0, 3) != 0, {$urandom(), $urandom()},
                $urandom_range(0, 6) != 0, $urandom_range(0, 6) != 0,
                $urandom_range(0, 4) != 0, $urandom_range(0, 12) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
